// File: rtl/battleship_pkg.sv
// Shared types, board limits and helpers for the battleship shot logic.
package battleship_pkg;

  localparam int unsigned COORD_W = 4;
  localparam int unsigned SHIP_W  = 5;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned BOMB_W  = 2;

  localparam logic [COORD_W-1:0] BOARD_MIN = COORD_W'(1);
  localparam logic [COORD_W-1:0] BOARD_MAX = COORD_W'(10);
  localparam logic [BOMB_W-1:0]  BIG_BOMBS = BOMB_W'(2);
  localparam logic [3:0]         MAX_HITS  = 4'd9;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(8);

  localparam logic [SHIP_W-1:0] SHIP_NONE       = 5'b00000;
  localparam logic [SHIP_W-1:0] SHIP_PATROL     = 5'b00001;
  localparam logic [SHIP_W-1:0] SHIP_DESTROYER  = 5'b00010;
  localparam logic [SHIP_W-1:0] SHIP_SUBMARINE  = 5'b00100;
  localparam logic [SHIP_W-1:0] SHIP_BATTLESHIP = 5'b01000;
  localparam logic [SHIP_W-1:0] SHIP_CARRIER    = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One square of a shot footprint; valid=0 means it lies off the board.
  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } cell_t;

  function automatic logic in_range(input logic [COORD_W-1:0] v);
    return (v >= BOARD_MIN) && (v <= BOARD_MAX);
  endfunction

  // Square for footprint index idx: big bombs walk a 3x3 block row-major, small ones only the centre.
  function automatic cell_t cell_at(input logic [COORD_W-1:0] cx,
                                    input logic [COORD_W-1:0] cy,
                                    input logic               big,
                                    input logic [IDX_W-1:0]   idx);
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    cell_t              c;
    col = COORD_W'(1);
    row = COORD_W'(1);
    if (big) begin
      case (idx)
        4'd0, 4'd1, 4'd2: row = COORD_W'(0);
        4'd3, 4'd4, 4'd5: row = COORD_W'(1);
        default:          row = COORD_W'(2);
      endcase
      case (idx)
        4'd0, 4'd3, 4'd6: col = COORD_W'(0);
        4'd1, 4'd4, 4'd7: col = COORD_W'(1);
        default:          col = COORD_W'(2);
      endcase
    end
    c.x     = cx + col - COORD_W'(1);
    c.y     = cy + row - COORD_W'(1);
    c.valid = in_range(c.x) && in_range(c.y);
    return c;
  endfunction

  // Keep only the most significant set bit (largest ship class).
  function automatic logic [SHIP_W-1:0] msb_onehot(input logic [SHIP_W-1:0] s);
    logic [SHIP_W-1:0] r;
    r = SHIP_NONE;
    for (int unsigned i = 0; i < SHIP_W; i++) begin
      if (s[i]) begin
        r    = SHIP_NONE;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Two-flop synchronizer for the active-low key plus a one-cycle falling-edge pulse.
module key_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic i_key_n,
  output logic o_press_c
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchronize the key and remember its previous synchronized level; reset means released.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_press_c = r_prev & ~r_sync2;

endmodule

// File: rtl/shot_sequencer.sv
// Sequences a single or 3x3 shot through the square evaluator and aggregates the result.
module shot_sequencer
  import battleship_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               score_n,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic               big,
  output logic               chk_valid,
  output logic [COORD_W-1:0] chk_x,
  output logic [COORD_W-1:0] chk_y,
  input  logic               chk_ready,
  input  logic               chk_hit,
  input  logic               chk_near,
  input  logic [SHIP_W-1:0]  chk_ship,
  output logic               shot_done,
  output logic               shot_hit,
  output logic               shot_near,
  output logic               shot_miss,
  output logic [SHIP_W-1:0]  biggest_ship,
  output logic [3:0]         num_hits,
  output logic [BOMB_W-1:0]  big_left,
  output logic               wrong,
  output logic               busy
);

  state_t              r_state, w_state_n;
  logic [COORD_W-1:0]  r_x, w_x_n;
  logic [COORD_W-1:0]  r_y, w_y_n;
  logic                r_big, w_big_n;
  logic [IDX_W-1:0]    r_idx, w_idx_n;
  logic                r_acc_hit, w_acc_hit_n;
  logic                r_acc_near, w_acc_near_n;
  logic [SHIP_W-1:0]   r_acc_ship, w_acc_ship_n;
  logic                r_chk_valid, w_chk_valid_n;
  logic [COORD_W-1:0]  r_chk_x, w_chk_x_n;
  logic [COORD_W-1:0]  r_chk_y, w_chk_y_n;
  logic                r_shot_done, w_shot_done_n;
  logic                r_shot_hit, w_shot_hit_n;
  logic                r_shot_near, w_shot_near_n;
  logic                r_shot_miss, w_shot_miss_n;
  logic [SHIP_W-1:0]   r_biggest, w_biggest_n;
  logic [3:0]          r_num_hits, w_num_hits_n;
  logic [BOMB_W-1:0]   r_big_left, w_big_left_n;
  logic                r_wrong, w_wrong_n;
  logic                r_busy;

  logic                w_press;
  logic                w_press_bad;
  logic                w_accept;
  logic                w_advance;
  logic                w_last;
  logic                w_acc_hit_upd;
  logic                w_acc_near_upd;
  logic [SHIP_W-1:0]   w_acc_ship_upd;
  logic [IDX_W-1:0]    w_idx_inc;
  cell_t               w_cell_first;
  cell_t               w_cell_next;

  key_edge_detect u_key (
    .clock     (clock),
    .reset     (reset),
    .i_key_n   (score_n),
    .o_press_c (w_press)
  );

  assign w_press_bad    = !in_range(x_in) || !in_range(y_in) ||
                          (big && (r_big_left == BOMB_W'(0)));
  assign w_accept       = r_chk_valid & chk_ready;
  assign w_advance      = ~r_chk_valid | chk_ready;
  assign w_last         = ~r_big | (r_idx == LAST_IDX);
  assign w_acc_hit_upd  = r_acc_hit  | (w_accept & chk_hit);
  assign w_acc_near_upd = r_acc_near | (w_accept & chk_near);
  assign w_acc_ship_upd = r_acc_ship | ({SHIP_W{w_accept}} & chk_ship);
  assign w_idx_inc      = r_idx + IDX_W'(1);
  assign w_cell_first   = cell_at(x_in, y_in, big, IDX_W'(0));
  assign w_cell_next    = cell_at(r_x, r_y, r_big, w_idx_inc);

  // Next-state and next-output decode; every registered output is computed one edge ahead.
  always_comb begin
    w_state_n     = r_state;
    w_x_n         = r_x;
    w_y_n         = r_y;
    w_big_n       = r_big;
    w_idx_n       = r_idx;
    w_acc_hit_n   = r_acc_hit;
    w_acc_near_n  = r_acc_near;
    w_acc_ship_n  = r_acc_ship;
    w_chk_valid_n = 1'b0;
    w_chk_x_n     = r_chk_x;
    w_chk_y_n     = r_chk_y;
    w_shot_done_n = 1'b0;
    w_shot_hit_n  = r_shot_hit;
    w_shot_near_n = r_shot_near;
    w_shot_miss_n = r_shot_miss;
    w_biggest_n   = r_biggest;
    w_num_hits_n  = r_num_hits;
    w_big_left_n  = r_big_left;
    w_wrong_n     = r_wrong;

    case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          w_x_n   = x_in;
          w_y_n   = y_in;
          w_big_n = big;
          if (w_press_bad) begin
            w_wrong_n = 1'b1;
          end else begin
            w_wrong_n     = 1'b0;
            w_state_n     = ST_ISSUE;
            w_idx_n       = IDX_W'(0);
            w_acc_hit_n   = 1'b0;
            w_acc_near_n  = 1'b0;
            w_acc_ship_n  = SHIP_NONE;
            w_chk_valid_n = w_cell_first.valid;
            w_chk_x_n     = w_cell_first.x;
            w_chk_y_n     = w_cell_first.y;
          end
        end
      end

      ST_ISSUE: begin
        w_acc_hit_n  = w_acc_hit_upd;
        w_acc_near_n = w_acc_near_upd;
        w_acc_ship_n = w_acc_ship_upd;
        if (w_advance) begin
          if (w_last) begin
            w_state_n     = ST_DONE;
            w_shot_done_n = 1'b1;
            w_shot_hit_n  = w_acc_hit_upd;
            w_shot_near_n = ~w_acc_hit_upd & w_acc_near_upd;
            w_shot_miss_n = ~w_acc_hit_upd & ~w_acc_near_upd;
            w_biggest_n   = msb_onehot(w_acc_ship_upd);
            if (w_acc_hit_upd && (r_num_hits < MAX_HITS)) begin
              w_num_hits_n = r_num_hits + 4'd1;
            end
            if (r_big && (r_big_left != BOMB_W'(0))) begin
              w_big_left_n = r_big_left - BOMB_W'(1);
            end
          end else begin
            w_idx_n       = w_idx_inc;
            w_chk_valid_n = w_cell_next.valid;
            w_chk_x_n     = w_cell_next.x;
            w_chk_y_n     = w_cell_next.y;
          end
        end else begin
          w_chk_valid_n = r_chk_valid;
        end
      end

      ST_DONE: begin
        w_state_n = ST_IDLE;
      end

      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_big       <= 1'b0;
      r_idx       <= '0;
      r_acc_hit   <= 1'b0;
      r_acc_near  <= 1'b0;
      r_acc_ship  <= SHIP_NONE;
      r_chk_valid <= 1'b0;
      r_chk_x     <= '0;
      r_chk_y     <= '0;
      r_shot_done <= 1'b0;
      r_shot_hit  <= 1'b0;
      r_shot_near <= 1'b0;
      r_shot_miss <= 1'b0;
      r_biggest   <= SHIP_NONE;
      r_num_hits  <= 4'd0;
      r_big_left  <= BIG_BOMBS;
      r_wrong     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_x         <= w_x_n;
      r_y         <= w_y_n;
      r_big       <= w_big_n;
      r_idx       <= w_idx_n;
      r_acc_hit   <= w_acc_hit_n;
      r_acc_near  <= w_acc_near_n;
      r_acc_ship  <= w_acc_ship_n;
      r_chk_valid <= w_chk_valid_n;
      r_chk_x     <= w_chk_x_n;
      r_chk_y     <= w_chk_y_n;
      r_shot_done <= w_shot_done_n;
      r_shot_hit  <= w_shot_hit_n;
      r_shot_near <= w_shot_near_n;
      r_shot_miss <= w_shot_miss_n;
      r_biggest   <= w_biggest_n;
      r_num_hits  <= w_num_hits_n;
      r_big_left  <= w_big_left_n;
      r_wrong     <= w_wrong_n;
      r_busy      <= (w_state_n != ST_IDLE);
    end
  end

  assign chk_valid    = r_chk_valid;
  assign chk_x        = r_chk_x;
  assign chk_y        = r_chk_y;
  assign shot_done    = r_shot_done;
  assign shot_hit     = r_shot_hit;
  assign shot_near    = r_shot_near;
  assign shot_miss    = r_shot_miss;
  assign biggest_ship = r_biggest;
  assign num_hits     = r_num_hits;
  assign big_left     = r_big_left;
  assign wrong        = r_wrong;
  assign busy         = r_busy;

endmodule

// File: tb/tb_shot_sequencer.sv
// Scoreboard bench for shot_sequencer with a fixed-board evaluator model.
module tb_shot_sequencer;

  logic       clock;
  logic       reset;
  logic       score_n;
  logic [3:0] x_in;
  logic [3:0] y_in;
  logic       big;
  logic       chk_valid;
  logic [3:0] chk_x;
  logic [3:0] chk_y;
  logic       chk_ready;
  logic       chk_hit;
  logic       chk_near;
  logic [4:0] chk_ship;
  logic       shot_done;
  logic       shot_hit;
  logic       shot_near;
  logic       shot_miss;
  logic [4:0] biggest_ship;
  logic [3:0] num_hits;
  logic [1:0] big_left;
  logic       wrong;
  logic       busy;

  shot_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .score_n      (score_n),
    .x_in         (x_in),
    .y_in         (y_in),
    .big          (big),
    .chk_valid    (chk_valid),
    .chk_x        (chk_x),
    .chk_y        (chk_y),
    .chk_ready    (chk_ready),
    .chk_hit      (chk_hit),
    .chk_near     (chk_near),
    .chk_ship     (chk_ship),
    .shot_done    (shot_done),
    .shot_hit     (shot_hit),
    .shot_near    (shot_near),
    .shot_miss    (shot_miss),
    .biggest_ship (biggest_ship),
    .num_hits     (num_hits),
    .big_left     (big_left),
    .wrong        (wrong),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int x;
    int y;
  } cell_e;

  typedef struct {
    logic       hit;
    logic       near;
    logic       miss;
    logic [4:0] ship;
    int         hits;
    int         bl;
    int         lat;
    int         iss;
  } res_e;

  cell_e cq[$];
  res_e  rq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int press_cyc = 0;
  int done_cnt = 0;
  int vld_cnt = 0;
  int iss_cnt = 0;
  int m_hits = 0;
  int m_big_left = 2;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Fixed board: patrol (7..8,6), battleship (1..4,2), carrier (10,6..10).
  function automatic logic [4:0] ship_at(input int x, input int y);
    if (y == 6 && (x == 7 || x == 8)) return 5'b00001;
    if (y == 2 && x >= 1 && x <= 4)   return 5'b01000;
    if (x == 10 && y >= 6 && y <= 10) return 5'b10000;
    return 5'b00000;
  endfunction

  function automatic logic near_at(input int x, input int y);
    return (ship_at(x - 1, y) != 0) || (ship_at(x + 1, y) != 0) ||
           (ship_at(x, y - 1) != 0) || (ship_at(x, y + 1) != 0);
  endfunction

  assign chk_ship = ship_at(int'(chk_x), int'(chk_y));
  assign chk_hit  = (chk_ship != 5'b00000);
  assign chk_near = near_at(int'(chk_x), int'(chk_y));

  always @(posedge clock) cyc <= cyc + 1;

  // Queue the squares and the aggregated result a shot should produce.
  task automatic push_expect(input int x, input int y, input bit b, input int stall);
    res_e       r;
    logic       h;
    logic       n;
    logic [4:0] s;
    cell_e      c;
    h = 1'b0;
    n = 1'b0;
    s = 5'b00000;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        c.x = x + dx;
        c.y = y + dy;
        if ((b || (dx == 0 && dy == 0)) && c.x >= 1 && c.x <= 10 && c.y >= 1 && c.y <= 10) begin
          cq.push_back(c);
          h = h | (ship_at(c.x, c.y) != 0);
          n = n | near_at(c.x, c.y);
          s = s | ship_at(c.x, c.y);
        end
      end
    end
    r.hit  = h;
    r.near = !h && n;
    r.miss = !h && !n;
    r.ship = 5'b00000;
    for (int i = 4; i >= 0; i--) begin
      if (s[i]) begin
        r.ship[i] = 1'b1;
        break;
      end
    end
    if (h && m_hits < 9) m_hits++;
    if (b) m_big_left--;
    r.hits = m_hits;
    r.bl   = m_big_left;
    r.lat  = 4 + stall + (b ? 8 : 0);
    r.iss  = 1 + stall + (b ? 8 : 0);
    rq.push_back(r);
  endtask

  // Monitor: evaluator handshakes and completed shots, sampled mid-cycle.
  always @(negedge clock) begin
    res_e r;
    if (!reset) begin
      if (chk_valid) begin
        vld_cnt++;
        if (cq.size() == 0) begin
          check_eq("chk_unexpected", int'(chk_valid), 0);
        end else begin
          check_eq("chk_x", int'(chk_x), cq[0].x);
          check_eq("chk_y", int'(chk_y), cq[0].y);
          if (chk_ready) void'(cq.pop_front());
        end
      end
      if (busy && !shot_done) iss_cnt++;
      if (shot_done) begin
        done_cnt++;
        if (rq.size() == 0) begin
          check_eq("done_unexpected", int'(shot_done), 0);
        end else begin
          r = rq.pop_front();
          check_eq("shot_hit", int'(shot_hit), int'(r.hit));
          check_eq("shot_near", int'(shot_near), int'(r.near));
          check_eq("shot_miss", int'(shot_miss), int'(r.miss));
          check_eq("biggest_ship", int'(biggest_ship), int'(r.ship));
          check_eq("num_hits", int'(num_hits), r.hits);
          check_eq("big_left", int'(big_left), r.bl);
          check_eq("latency", cyc - press_cyc, r.lat);
          check_eq("issue_cycles", iss_cnt, r.iss);
          check_eq("cells_left", cq.size(), 0);
        end
        iss_cnt = 0;
      end
      if (!busy) iss_cnt = 0;
    end
  end

  // Press the key for one shot; optional evaluator stall and a second press while busy.
  task automatic do_shot(input int x, input int y, input bit b, input int stall, input bit repress);
    bit bad;
    int d0;
    int v0;
    int j;
    bad = (x < 1 || x > 10 || y < 1 || y > 10 || (b && m_big_left == 0));
    if (!bad) push_expect(x, y, b, stall);
    d0 = done_cnt;
    v0 = vld_cnt;
    j  = 0;
    x_in = 4'(x);
    y_in = 4'(y);
    big  = b;
    chk_ready = (stall == 0);
    @(posedge clock);
    #1 score_n = 1'b0;
    press_cyc = cyc;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clock);
      #1;
      if (t == 3 || t == 9) score_n = 1'b1;
      if (t == 6 && repress) score_n = 1'b0;
      if (busy) begin
        j++;
        if (j > stall) chk_ready = 1'b1;
      end
      if (!bad && done_cnt != d0 && t >= 9) break;
      if (bad && t >= 12) break;
    end
    chk_ready = 1'b1;
    repeat (repress ? 16 : 3) @(posedge clock);
    #1;
    if (bad) begin
      check_eq("wrong_set", int'(wrong), 1);
      check_eq("wrong_busy", int'(busy), 0);
      check_eq("wrong_no_done", done_cnt - d0, 0);
      check_eq("wrong_no_valid", vld_cnt - v0, 0);
      check_eq("wrong_hits", int'(num_hits), m_hits);
      check_eq("wrong_big_left", int'(big_left), m_big_left);
    end else begin
      check_eq("done_count", done_cnt - d0, 1);
      check_eq("wrong_clear", int'(wrong), 0);
    end
  endtask

  int tx[10] = '{7, 8, 1, 2, 3, 4, 10, 10, 10, 10};
  int ty[10] = '{6, 6, 2, 2, 2, 2, 6, 7, 8, 9};
  int d0;

  initial begin
    reset     = 1'b1;
    score_n   = 1'b1;
    x_in      = 4'd0;
    y_in      = 4'd0;
    big       = 1'b0;
    chk_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_eq("rst_chk_valid", int'(chk_valid), 0);
    check_eq("rst_shot_done", int'(shot_done), 0);
    check_eq("rst_shot_hit", int'(shot_hit), 0);
    check_eq("rst_shot_near", int'(shot_near), 0);
    check_eq("rst_shot_miss", int'(shot_miss), 0);
    check_eq("rst_biggest", int'(biggest_ship), 0);
    check_eq("rst_num_hits", int'(num_hits), 0);
    check_eq("rst_big_left", int'(big_left), 2);
    check_eq("rst_wrong", int'(wrong), 0);
    check_eq("rst_busy", int'(busy), 0);

    do_shot(7, 6, 1'b0, 0, 1'b0);
    do_shot(1, 1, 1'b1, 0, 1'b0);
    do_shot(11, 5, 1'b0, 0, 1'b0);
    do_shot(5, 5, 1'b0, 3, 1'b0);
    do_shot(10, 10, 1'b1, 0, 1'b0);
    do_shot(4, 4, 1'b1, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      do_shot(tx[i], ty[i], 1'b0, (i == 2) ? 10 : 0, i == 2);
    end
    check_eq("sat_hits", int'(num_hits), 9);

    // Plain reset, then a big shot aborted by reset in the middle of its footprint.
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    m_hits = 0;
    m_big_left = 2;
    push_expect(3, 3, 1'b1, 0);
    d0 = done_cnt;
    x_in = 4'd3;
    y_in = 4'd3;
    big  = 1'b1;
    chk_ready = 1'b1;
    @(posedge clock);
    #1 score_n = 1'b0;
    press_cyc = cyc;
    for (int t = 1; t <= 6; t++) begin
      @(posedge clock);
      #1;
      if (t == 3) score_n = 1'b1;
    end
    check_eq("abort_busy_before", int'(busy), 1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    cq.delete();
    rq.delete();
    m_hits = 0;
    m_big_left = 2;
    @(negedge clock);
    check_eq("abort_chk_valid", int'(chk_valid), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_big_left", int'(big_left), 2);
    check_eq("abort_shot_done", int'(shot_done), 0);
    repeat (15) @(posedge clock);
    #1;
    check_eq("abort_no_done", done_cnt - d0, 0);

    do_shot(7, 6, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    check_eq("watchdog", 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
